// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one synchronous memory port between two requesters
// Supports locked bursts capped by a starvation limit; read data is tagged by a registered per-requester strobe.

module mem_port_arbiter #(
  parameter int DATA     = 18,
  parameter int ADDR     = 14,
  parameter int MAX_LOCK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            req1,
  input  logic            lock0,
  input  logic            lock1,
  input  logic            wr0,
  input  logic            wr1,
  input  logic [ADDR-1:0] addr0,
  input  logic [ADDR-1:0] addr1,
  input  logic [DATA-1:0] din0,
  input  logic [DATA-1:0] din1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic            rvalid1,
  output logic [DATA-1:0] rdata,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             last_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             win0;
  logic             win1;

  always_comb begin
    win0      = 1'b0;
    win1      = 1'b0;
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = lock_cnt;
    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (req0 && (!req1 || last)) begin
          win0     = 1'b1;
          last_nxt = 1'b0;
          if (lock0) begin
            state_nxt = LOCK0;
            cnt_nxt   = CNT_ONE;
          end
        end else if (req1) begin
          win1     = 1'b1;
          last_nxt = 1'b1;
          if (lock1) begin
            state_nxt = LOCK1;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      LOCK0: begin
        if (!req0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (lock_cnt >= CNT_MAX && req1) begin
          // Burst exhausted its budget while requester 1 waits: hand over.
          state_nxt = IDLE;
          last_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          win0     = 1'b1;
          last_nxt = 1'b0;
          if (!lock0) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (lock_cnt >= CNT_MAX) begin
            cnt_nxt = CNT_ONE;
          end else begin
            cnt_nxt = lock_cnt + CNT_ONE;
          end
        end
      end
      LOCK1: begin
        if (!req1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (lock_cnt >= CNT_MAX && req0) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          win1     = 1'b1;
          last_nxt = 1'b1;
          if (!lock1) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (lock_cnt >= CNT_MAX) begin
            cnt_nxt = CNT_ONE;
          end else begin
            cnt_nxt = lock_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign gnt0 = rst_n & win0;
  assign gnt1 = rst_n & win1;

  always_comb begin
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt0) begin
      mem_wr   = wr0;
      mem_addr = addr0;
      mem_din  = din0;
    end else if (gnt1) begin
      mem_wr   = wr1;
      mem_addr = addr1;
      mem_din  = din1;
    end
  end

  assign rdata = mem_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= cnt_nxt;
      rvalid0  <= gnt0 & ~wr0;
      rvalid1  <= gnt1 & ~wr1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// A behavioural synchronous memory supplies read data; unwritten words read back as {4'hA, addr}.

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, lock0, lock1, wr0, wr1;
  logic [13:0] addr0, addr1;
  logic [17:0] din0, din1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wr;
  logic [17:0] rdata, mem_din, mem_dout;
  logic [13:0] mem_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] wmem [0:16383];
  bit   [16383:0] wvalid;
  logic [13:0] prev_addr;
  int          n_g0;

  mem_port_arbiter #(.DATA(18), .ADDR(14), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .wr0(wr0), .wr1(wr1), .addr0(addr0), .addr1(addr1),
    .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] fill(input logic [13:0] a);
    return {4'hA, a};
  endfunction

  always @(posedge clk) begin
    if (mem_wr) begin
      wmem[mem_addr]   <= mem_din;
      wvalid[mem_addr] <= 1'b1;
    end
    mem_dout <= wvalid[mem_addr] ? wmem[mem_addr] : fill(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; lock0 = 1'b0; lock1 = 1'b0;
    wr0 = 1'b1; wr1 = 1'b1;
    addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;

    // Reset with both requesting writes: nothing may reach the memory.
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rst_gnt0", 32'(gnt0), 0);
      check("rst_gnt1", 32'(gnt1), 0);
      check("rst_mem_wr", 32'(mem_wr), 0);
      cyc();
    end

    // Round robin reads, starting right at reset release.
    rst_n = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      addr0 = 14'h100 + 14'(i);
      addr1 = 14'h200 + 14'(i);
      settle();
      if (i == 0) begin
        check("rst_rvalid0", 32'(rvalid0), 0);
        check("rst_rvalid1", 32'(rvalid1), 0);
      end else begin
        check("rr_rvalid0", 32'(rvalid0), 32'(i % 2 == 1));
        check("rr_rvalid1", 32'(rvalid1), 32'(i % 2 == 0));
        check("rr_rdata", 32'(rdata), 32'(fill(prev_addr)));
      end
      check("rr_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      check("rr_gnt1", 32'(gnt1), 32'(i % 2 == 1));
      prev_addr = (i % 2 == 0) ? addr0 : addr1;
      check("rr_mem_addr", 32'(mem_addr), 32'(prev_addr));
      check("rr_mem_wr", 32'(mem_wr), 0);
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0;
    settle();
    check("rr_tail_rvalid1", 32'(rvalid1), 1);
    check("rr_tail_rdata", 32'(rdata), 32'h28205);
    check("rr_tail_gnt", 32'({gnt0, gnt1}), 0);
    cyc();

    // Write then read back through requester 1.
    req1 = 1'b1; wr1 = 1'b1; addr1 = 14'h0005; din1 = 18'h2AAAA;
    settle();
    check("wr_gnt1", 32'(gnt1), 1);
    check("wr_mem_wr", 32'(mem_wr), 1);
    check("wr_mem_addr", 32'(mem_addr), 32'h5);
    check("wr_mem_din", 32'(mem_din), 32'h2AAAA);
    cyc();
    wr1 = 1'b0;
    settle();
    check("wr_no_rvalid", 32'(rvalid1), 0);
    check("rd_gnt1", 32'(gnt1), 1);
    check("rd_mem_wr", 32'(mem_wr), 0);
    cyc();
    req1 = 1'b0;
    settle();
    check("rd_rvalid1", 32'(rvalid1), 1);
    check("rd_rdata", 32'(rdata), 32'h2AAAA);
    cyc();

    // Locked burst of 4 beats from requester 0 while requester 1 waits.
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; addr1 = 14'h0020;
    for (int i = 0; i < 4; i++) begin
      addr0 = 14'h010 + 14'(i);
      if (i == 3) lock0 = 1'b0;
      settle();
      check("lock_gnt0", 32'(gnt0), 1);
      check("lock_gnt1", 32'(gnt1), 0);
      if (i > 0) check("lock_rdata", 32'(rdata), 32'(fill(addr0 - 14'd1)));
      cyc();
    end
    req0 = 1'b0;
    settle();
    check("lock_handover_gnt1", 32'(gnt1), 1);
    check("lock_handover_addr", 32'(mem_addr), 32'h20);
    check("lock_coincide_rvalid0", 32'(rvalid0), 1);
    check("lock_coincide_rdata", 32'(rdata), 32'h28013);
    cyc();
    req1 = 1'b0;
    settle();
    check("lock_rvalid1", 32'(rvalid1), 1);
    check("lock_rdata1", 32'(rdata), 32'h28020);
    cyc();

    // Starvation cap: 4 locked beats, one idle handover cycle, then requester 1.
    req0 = 1'b1; lock0 = 1'b1; wr0 = 1'b1; addr0 = 14'h0030; din0 = 18'h12345;
    req1 = 1'b1;
    n_g0 = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (gnt0) n_g0++;
      if (i == 4) check("starve_gap", 32'({gnt0, gnt1}), 0);
      if (i == 5) check("starve_gnt1", 32'({gnt0, gnt1}), 1);
      cyc();
    end
    check("starve_gnt0_count", 32'(n_g0), 4);

    // Alone, a locked requester renews past the cap without a gap.
    req1 = 1'b0;
    n_g0 = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (gnt0) n_g0++;
      cyc();
    end
    check("renew_gnt0_count", 32'(n_g0), 10);
    req0 = 1'b0; req1 = 1'b1;
    settle();
    check("unlock_no_rearb", 32'({gnt0, gnt1}), 0);
    cyc();
    settle();
    check("unlock_gnt1", 32'(gnt1), 1);
    cyc();
    req1 = 1'b0;

    // Reset while a read is in flight and a lock is held.
    req0 = 1'b1; lock0 = 1'b1; wr0 = 1'b0; addr0 = 14'h0040;
    settle();
    check("mid_gnt0", 32'(gnt0), 1);
    cyc();
    rst_n = 1'b0;
    settle();
    check("mid_rst_gnt0", 32'(gnt0), 0);
    check("mid_inflight_rvalid0", 32'(rvalid0), 1);
    cyc();
    rst_n = 1'b1; req0 = 1'b0; lock0 = 1'b0; req1 = 1'b1; addr1 = 14'h0041;
    settle();
    check("mid_rvalid0_dropped", 32'(rvalid0), 0);
    check("mid_idle_gnt1", 32'(gnt1), 1);
    cyc();
    req1 = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
